// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative L1 cache (I$ and D$).
// Contents: controller state enum, derived address-field widths,
// victim-selection function and byte-merge function.
package cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   localparam int unsigned MAX_WAYS     = 8;
   localparam int unsigned MAX_WAY_BITS = 3;

   // Byte offset bits within a line (word offset + byte-in-word).
   function automatic int unsigned off_bits(input int unsigned line_bits);
      return line_bits + 2;
   endfunction

   function automatic int unsigned tag_bits(input int unsigned set_bits,
                                            input int unsigned line_bits);
      return 32 - set_bits - line_bits - 2;
   endfunction

   // Lowest-index invalid way wins; with a full set, the way after MRU.
   function automatic logic [MAX_WAY_BITS-1:0] victim_pick(
      input logic [MAX_WAYS-1:0]     valid,
      input logic [MAX_WAY_BITS-1:0] mru,
      input int unsigned             ways);
      logic [MAX_WAY_BITS-1:0] v;
      logic                    found;
      v     = MAX_WAY_BITS'((32'(mru) + 32'd1) % ways);
      found = 1'b0;
      for (int unsigned w = 0; w < MAX_WAYS; w++) begin
         if (w < ways && !found && !valid[MAX_WAY_BITS'(w)]) begin
            v     = MAX_WAY_BITS'(w);
            found = 1'b1;
         end
      end
      return v;
   endfunction

   // Replace the bytes of old_w selected by mask with the bytes of new_w.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
      logic [31:0] m;
      for (int unsigned b = 0; b < 4; b++) begin
         m[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational replacement-way selector for one set.
// Ports: i_valid    - valid bit per way of the addressed set
//        i_mru      - most recently used way of that set
//        o_victim_c - way to refill on a miss
module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int unsigned WAYS     = 2,
   parameter int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0]     i_valid,
   input  logic [WAY_BITS-1:0] i_mru,
   output logic [WAY_BITS-1:0] o_victim_c
);

   always_comb begin
      o_victim_c = WAY_BITS'(victim_pick(MAX_WAYS'(i_valid), MAX_WAY_BITS'(i_mru), WAYS));
   end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-through / write-allocate L1 cache.
// Hart side:   i_req_addr/ren/wen/mask/wdata, o_res_rdata, o_busy (stall).
// Memory side: o_mem_addr/ren/wen/wdata, i_mem_ready/rdata/valid/wdone.
// Control:     i_flush walks all sets clearing valid bits.
// Optional:    define CACHE_STATS_EN to add saturating o_hits/o_misses.
module cache_assoc
   import cache_pkg::*;
#(
   parameter int unsigned WAYS      = 2,
   parameter int unsigned SET_BITS  = 5,
   parameter int unsigned LINE_BITS = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_valid,
   input  logic        i_mem_wdone,
   input  logic        i_flush,
   output logic        o_busy,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [3:0]  i_req_mask,
   input  logic [31:0] i_req_wdata,
   output logic [31:0] o_res_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] o_hits,
   output logic [31:0] o_misses
`endif
);

   localparam int unsigned OFF_BITS = off_bits(LINE_BITS);
   localparam int unsigned TAG_BITS = tag_bits(SET_BITS, LINE_BITS);
   localparam int unsigned SETS     = 32'd1 << SET_BITS;
   localparam int unsigned WORDS    = 32'd1 << LINE_BITS;
   localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned CNT_BITS = LINE_BITS + 1;

   state_t                r_state, w_next;
   logic [31:0]           r_data  [WAYS][SETS][WORDS];
   logic [TAG_BITS-1:0]   r_tag   [WAYS][SETS];
   logic [SETS-1:0]       r_valid [WAYS];
   logic [WAY_BITS-1:0]   r_mru   [SETS];

   logic [31:0]           r_addr, r_wdata, r_merged;
   logic                  r_wen, r_rd_out, r_wr_issued;
   logic [3:0]            r_mask;
   logic [WAY_BITS-1:0]   r_victim;
   logic [CNT_BITS-1:0]   r_req_cnt, r_rcv_cnt;
   logic [SET_BITS-1:0]   r_flush_set;

   logic [SET_BITS-1:0]   w_set, w_lset;
   logic [TAG_BITS-1:0]   w_tag, w_ltag;
   logic [LINE_BITS-1:0]  w_off, w_loff;
   logic [WAYS-1:0]       w_valid_vec;
   logic                  w_hit, w_idle, w_rd_acc, w_rd_hit;
   logic                  w_enter_fill, w_enter_wr, w_enter_flush, w_fill_rx, w_fill_done;
   logic [WAY_BITS-1:0]   w_hit_way, w_victim;
   logic [31:0]           w_rdata, w_fill_base, w_merge_fill, w_merge_hit;

   assign w_set  = i_req_addr[OFF_BITS +: SET_BITS];
   assign w_tag  = i_req_addr[31 -: TAG_BITS];
   assign w_off  = i_req_addr[2 +: LINE_BITS];
   assign w_lset = r_addr[OFF_BITS +: SET_BITS];
   assign w_ltag = r_addr[31 -: TAG_BITS];
   assign w_loff = r_addr[2 +: LINE_BITS];

   // Tag compare against the live request address.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_valid_vec = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         w_valid_vec[w] = r_valid[w][w_set];
         if (r_valid[w][w_set] && r_tag[w][w_set] == w_tag) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_BITS'(w);
         end
      end
      w_rdata     = w_hit ? r_data[w_hit_way][w_set][w_off] : '0;
      o_res_rdata = w_rdata;
   end

   cache_victim_sel #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_victim (
      .i_valid    (w_valid_vec),
      .i_mru      (r_mru[w_set]),
      .o_victim_c (w_victim)
   );

   assign w_idle        = (r_state == S_IDLE);
   assign w_rd_acc      = w_idle && !i_flush && i_req_ren && !i_req_wen;
   assign w_rd_hit      = w_rd_acc && w_hit;
   assign w_enter_fill  = w_idle && (w_next == S_FILL);
   assign w_enter_wr    = w_idle && (w_next == S_WRITE);
   assign w_enter_flush = w_idle && (w_next == S_FLUSH);
   assign w_fill_rx     = (r_state == S_FILL) && i_mem_valid && r_rd_out;
   assign w_fill_done   = w_fill_rx && (r_rcv_cnt == CNT_BITS'(WORDS - 1));
   // The last fill word is still on the bus when the merge happens.
   assign w_fill_base   = (w_loff == LINE_BITS'(WORDS - 1)) ? i_mem_rdata
                                                            : r_data[r_victim][w_lset][w_loff];
   assign w_merge_fill  = merge_bytes(w_fill_base, r_wdata, r_mask);
   assign w_merge_hit   = merge_bytes(w_rdata, i_req_wdata, i_req_mask);

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next state and stall.
   always_comb begin
      w_next = r_state;
      o_busy = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_busy = i_flush || i_req_wen || (i_req_ren && !w_hit);
            if (i_flush)                   w_next = S_FLUSH;
            else if (i_req_wen)            w_next = w_hit ? S_WRITE : S_FILL;
            else if (i_req_ren && !w_hit)  w_next = S_FILL;
         end
         S_FILL:  if (w_fill_done) w_next = r_wen ? S_WRITE : S_IDLE;
         S_WRITE: if (r_wr_issued && i_mem_wdone) w_next = S_IDLE;
         S_FLUSH: if (r_flush_set == SET_BITS'(SETS - 1)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Line storage; intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (w_fill_rx)
         r_data[r_victim][w_lset][r_rcv_cnt[LINE_BITS-1:0]] <= i_mem_rdata;
      if (w_fill_done) begin
         r_tag[r_victim][w_lset] <= w_ltag;
         if (r_wen) r_data[r_victim][w_lset][w_loff] <= w_merge_fill;
      end
      if (w_enter_wr)
         r_data[w_hit_way][w_set][w_off] <= w_merge_hit;
   end

   // Valid/MRU state, request latch and memory interface.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned w = 0; w < WAYS; w++) r_valid[w] <= '0;
         for (int unsigned s = 0; s < SETS; s++) r_mru[s] <= '0;
         o_mem_ren   <= 1'b0;
         o_mem_wen   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_merged    <= '0;
         r_mask      <= '0;
         r_wen       <= 1'b0;
         r_victim    <= '0;
         r_req_cnt   <= '0;
         r_rcv_cnt   <= '0;
         r_rd_out    <= 1'b0;
         r_wr_issued <= 1'b0;
         r_flush_set <= '0;
      end else begin
         o_mem_ren <= 1'b0;
         o_mem_wen <= 1'b0;
         if (w_enter_fill || w_enter_wr) begin
            r_addr      <= i_req_addr;
            r_wen       <= i_req_wen;
            r_mask      <= i_req_mask;
            r_wdata     <= i_req_wdata;
            r_victim    <= w_victim;
            r_req_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_rd_out    <= 1'b0;
            r_wr_issued <= 1'b0;
         end
         if (w_enter_wr) r_merged <= w_merge_hit;
         if (w_rd_hit)   r_mru[w_set] <= w_hit_way;
         if (w_enter_flush) begin
            for (int unsigned w = 0; w < WAYS; w++) r_valid[w][0] <= 1'b0;
            r_flush_set <= SET_BITS'(1);
         end
         case (r_state)
            S_FILL: begin
               if (w_fill_rx) begin
                  r_rd_out  <= 1'b0;
                  r_rcv_cnt <= r_rcv_cnt + CNT_BITS'(1);
               end
               if (i_mem_ready && !r_rd_out && r_req_cnt < CNT_BITS'(WORDS)) begin
                  o_mem_ren  <= 1'b1;
                  o_mem_addr <= {r_addr[31:OFF_BITS], r_req_cnt[LINE_BITS-1:0], 2'b00};
                  r_req_cnt  <= r_req_cnt + CNT_BITS'(1);
                  r_rd_out   <= 1'b1;
               end
               if (w_fill_done) begin
                  r_valid[r_victim][w_lset] <= 1'b1;
                  r_mru[w_lset]             <= r_victim;
                  r_merged                  <= w_merge_fill;
                  r_wr_issued               <= 1'b0;
               end
            end
            S_WRITE: begin
               if (!r_wr_issued && i_mem_ready) begin
                  o_mem_wen   <= 1'b1;
                  o_mem_addr  <= r_addr & ~32'h3;
                  o_mem_wdata <= r_merged;
                  r_wr_issued <= 1'b1;
               end
            end
            S_FLUSH: begin
               for (int unsigned w = 0; w < WAYS; w++) r_valid[w][r_flush_set] <= 1'b0;
               r_flush_set <= r_flush_set + SET_BITS'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic w_acc;
   assign w_acc = w_idle && !i_flush && (i_req_ren || i_req_wen);

   // Saturating hit/miss counters over requests accepted in IDLE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_hits   <= '0;
         o_misses <= '0;
      end else if (w_acc) begin
         if (w_hit && o_hits != '1)         o_hits   <= o_hits + 32'd1;
         else if (!w_hit && o_misses != '1) o_misses <= o_misses + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
module tb_cache_assoc;

   localparam int unsigned WAYS      = 2;
   localparam int unsigned SET_BITS  = 5;
   localparam int unsigned LINE_BITS = 2;
   localparam int unsigned SETS      = 1 << SET_BITS;
   localparam int unsigned WORDS     = 1 << LINE_BITS;
   localparam int unsigned OFFB      = LINE_BITS + 2;

   logic        clk, rst;
   logic        mem_ready, mem_ren, mem_wen, mem_valid, mem_wdone;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        flush, busy, req_ren, req_wen;
   logic [31:0] req_addr, req_wdata, res_rdata;
   logic [3:0]  req_mask;

   cache_assoc #(.WAYS(WAYS), .SET_BITS(SET_BITS), .LINE_BITS(LINE_BITS)) dut (
      .i_clk(clk), .i_rst(rst), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
      .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid), .i_mem_wdone(mem_wdone),
      .i_flush(flush), .o_busy(busy), .i_req_addr(req_addr), .i_req_ren(req_ren),
      .i_req_wen(req_wen), .i_req_mask(req_mask), .i_req_wdata(req_wdata),
      .o_res_rdata(res_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   logic [31:0] rd_log[$];
   wr_t         wr_log[$];
   logic [31:0] mem [logic [31:0]];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   // Reference model: per-set list of ways with valid/tag/words and an MRU way.
   bit          m_v   [WAYS][SETS];
   logic [31:0] m_tag [WAYS][SETS];
   logic [31:0] m_dat [WAYS][SETS][WORDS];
   int          m_mru [SETS];

   task automatic model_invalidate(input bit clear_mru);
      for (int s = 0; s < int'(SETS); s++) begin
         for (int w = 0; w < int'(WAYS); w++) m_v[w][s] = 1'b0;
         if (clear_mru) m_mru[s] = 0;
      end
   endtask

   task automatic model_access(input logic [31:0] a, input bit wr, input logic [3:0] m,
                               input logic [31:0] wd, output bit hit, output logic [31:0] rd);
      int s, off, way;
      logic [31:0] tg, base, w;
      s   = int'((a >> OFFB) % SETS);
      off = int'((a >> 2) % WORDS);
      tg  = a >> (OFFB + SET_BITS);
      way = -1;
      for (int i = 0; i < int'(WAYS); i++) if (m_v[i][s] && m_tag[i][s] == tg) way = i;
      hit = (way >= 0);
      if (!hit) begin
         for (int i = int'(WAYS) - 1; i >= 0; i--) if (!m_v[i][s]) way = i;
         if (way < 0) way = (m_mru[s] + 1) % int'(WAYS);
         base = a & ~32'(WORDS * 4 - 1);
         for (int k = 0; k < int'(WORDS); k++) m_dat[way][s][k] = mem_rd(base + 32'(4 * k));
         m_v[way][s]   = 1'b1;
         m_tag[way][s] = tg;
         m_mru[s]      = way;
      end else if (!wr) begin
         m_mru[s] = way;
      end
      if (wr) begin
         w = m_dat[way][s][off];
         for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
         m_dat[way][s][off] = w;
      end
      rd = m_dat[way][s][off];
   endtask

   // Memory: random ready, random 0..2 cycle extra latency, one request at a time.
   bit          pend_r, pend_w;
   int          dly_r, dly_w;
   logic [31:0] raddr;
   initial begin
      mem_valid = 0; mem_wdone = 0; mem_ready = 0; mem_rdata = 0;
      pend_r = 0; pend_w = 0; dly_r = 0; dly_w = 0; raddr = 0;
      forever begin
         @(posedge clk); #1;
         mem_valid = 0;
         mem_wdone = 0;
         mem_ready = ($urandom_range(0, 3) != 0);
         if (rst) begin
            pend_r = 0;
            pend_w = 0;
         end else begin
            if (pend_r) begin
               if (dly_r == 0) begin mem_valid = 1; mem_rdata = mem_rd(raddr); pend_r = 0; end
               else dly_r--;
            end
            if (pend_w) begin
               if (dly_w == 0) begin mem_wdone = 1; pend_w = 0; end
               else dly_w--;
            end
            if (mem_ren) begin
               rd_log.push_back(mem_addr);
               raddr = mem_addr; pend_r = 1; dly_r = int'($urandom_range(0, 2));
            end
            if (mem_wen) begin
               wr_log.push_back('{mem_addr, mem_wdata});
               mem[mem_addr] = mem_wdata; pend_w = 1; dly_w = int'($urandom_range(0, 2));
            end
         end
      end
   end

   // One hart transaction, checked against the model; returns reads issued and busy cycles.
   task automatic do_op(input logic [31:0] a, input bit wr, input logic [3:0] m,
                        input logic [31:0] wd, output int nrd, output int bcnt);
      bit hit;
      logic [31:0] exp_rd;
      int r0, w0, guard;
      model_access(a, wr, m, wd, hit, exp_rd);
      r0 = rd_log.size(); w0 = wr_log.size();
      @(negedge clk);
      req_addr = a; req_ren = !wr; req_wen = wr; req_mask = m; req_wdata = wd;
      #1;
      chk("busy_at_req", 32'(busy), 32'(!(!wr && hit)));
      if (!wr && hit) chk("hit_rdata", res_rdata, exp_rd);
      bcnt = busy ? 1 : 0;
      @(negedge clk);
      req_ren = 0; req_wen = 0;
      #1;
      guard = 0;
      while (busy && guard < 400) begin
         bcnt++; guard++;
         @(negedge clk); #1;
      end
      if (busy) chk("busy_timeout", 32'(busy), 32'd0);
      nrd = rd_log.size() - r0;
      chk("done_rdata", res_rdata, exp_rd);
      chk("n_mem_reads", 32'(nrd), hit ? 32'd0 : 32'(WORDS));
      chk("n_mem_writes", 32'(wr_log.size() - w0), 32'(wr));
      if (wr && wr_log.size() > w0) begin
         chk("wr_addr", wr_log[w0].addr, a);
         chk("wr_data", wr_log[w0].data, exp_rd);
      end
   endtask

   task automatic do_flush(output int bcnt);
      int guard;
      @(negedge clk);
      flush = 1;
      #1;
      bcnt = busy ? 1 : 0;
      @(negedge clk);
      flush = 0;
      #1;
      guard = 0;
      while (busy && guard < 200) begin
         bcnt++; guard++;
         @(negedge clk); #1;
      end
      model_invalidate(1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrd, bc, r0, guard;
      logic [31:0] a, wd;
      rst = 1; flush = 0; req_addr = 0; req_ren = 0; req_wen = 0; req_mask = 0; req_wdata = 0;
      model_invalidate(1'b1);
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ren", 32'(mem_ren), 32'd0);
      chk("rst_wen", 32'(mem_wen), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst = 0;

      // Read miss then reread from the same line.
      mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
      r0 = rd_log.size();
      do_op(32'h100, 0, 4'h0, 0, nrd, bc);
      for (int k = 0; k < 4; k++) chk("fill_addr", rd_log[r0 + k], 32'h100 + 32'(4 * k));
      chk("fill_busy_ge5", 32'(bc >= 5), 32'd1);
      chk("fill_rdata", res_rdata, 32'h11);
      do_op(32'h104, 0, 4'h0, 0, nrd, bc);
      chk("reread_busy", 32'(bc), 32'd0);
      chk("reread_rdata", res_rdata, 32'h22);

      // Replacement in set 3: A, B, A, C -> C evicts B.
      do_op(32'h230, 0, 4'h0, 0, nrd, bc);
      do_op(32'h430, 0, 4'h0, 0, nrd, bc);
      do_op(32'h230, 0, 4'h0, 0, nrd, bc);
      do_op(32'h630, 0, 4'h0, 0, nrd, bc);
      do_op(32'h230, 0, 4'h0, 0, nrd, bc);
      chk("lru_a_kept", 32'(nrd), 32'd0);
      do_op(32'h430, 0, 4'h0, 0, nrd, bc);
      chk("lru_b_evicted", 32'(nrd), 32'd4);

      // Masked write hit, then zero-mask write, then readback.
      do_op(32'h104, 1, 4'hF, 32'h2222_2222, nrd, bc);
      do_op(32'h104, 1, 4'b0010, 32'h0000_AB00, nrd, bc);
      chk("mwr_memword", wr_log[$].data, 32'h2222_AB22);
      do_op(32'h104, 1, 4'b0000, 32'hFFFF_FFFF, nrd, bc);
      chk("mask0_memword", wr_log[$].data, 32'h2222_AB22);
      do_op(32'h104, 0, 4'h0, 0, nrd, bc);
      chk("mwr_readback", res_rdata, 32'h2222_AB22);

      // Write miss: fill then merged write-through.
      mem[32'h200] = 32'h1234_5678;
      do_op(32'h200, 1, 4'b0001, 32'h0000_00EE, nrd, bc);
      chk("wmiss_memword", wr_log[$].data, 32'h1234_56EE);
      chk("wmiss_busy", 32'(busy), 32'd0);

      // Flush: 32 busy cycles, then old lines miss.
      do_flush(bc);
      chk("flush_busy_cycles", 32'(bc), 32'd32);
      do_op(32'h100, 0, 4'h0, 0, nrd, bc);
      do_op(32'h230, 0, 4'h0, 0, nrd, bc);

      // Asynchronous reset during fill of line 0x300.
      do_flush(bc);
      @(negedge clk);
      req_addr = 32'h300; req_ren = 1;
      r0 = rd_log.size();
      @(negedge clk);
      req_ren = 0;
      guard = 0;
      while (rd_log.size() - r0 < 3 && guard < 200) begin @(negedge clk); guard++; end
      chk("mid_fill_reached", 32'(rd_log.size() - r0 >= 3), 32'd1);
      #2 rst = 1;
      #1;
      chk("async_rst_ren", 32'(mem_ren), 32'd0);
      chk("async_rst_addr", mem_addr, 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 0;
      model_invalidate(1'b1);
      do_op(32'h300, 0, 4'h0, 0, nrd, bc);
      chk("refetch_reads", 32'(nrd), 32'd4);

      // Randomized traffic over two sets and three tags (forces evictions).
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_flush(bc);
            chk("rand_flush_cycles", 32'(bc), 32'd32);
         end else begin
            a  = (32'($urandom_range(1, 3)) << (OFFB + SET_BITS))
               | (($urandom_range(0, 1) != 0 ? 32'd3 : 32'd17) << OFFB)
               | (32'($urandom_range(0, WORDS - 1)) << 2);
            wd = $urandom;
            do_op(a, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), wd, nrd, bc);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
